// File: rtl/ixc_gfifo_buf.sv
// rtl/ixc_gfifo_buf.sv - circular FIFO buffer between gfifo glue and its consumer
module ixc_gfifo_buf #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     afull,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Flags decode from the registered occupancy only, so in_ready never
  // depends combinationally on out_ready; a full FIFO refuses a push even
  // when the head is popped in the same cycle.
  always_comb begin
    in_ready  = (cnt != CW'(DEPTH));
    out_valid = (cnt != '0);
    afull     = (cnt >= CW'(AFULL_LVL));
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    count     = cnt;
    // Head is driven to zero while empty so the post-reset output is defined
    // even though the storage array itself is never cleared.
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

  // Storage array: written on an accepted push, not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and sticky overflow; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
      // The glue cannot stall, so a refused word is lost; flag it until reset.
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
